// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;
  // Low PC bits that must be cleared to word-align an address.
  localparam int unsigned PC_LOW_MASK = INST_BYTES - 1;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush; flush overrides a same-cycle push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot that cycle.
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: runs ahead on a valid/ready bus into a {pc, inst} FIFO,
// with backend redirects flushing the FIFO and discarding any in-flight response.
module ifetch_prefetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  i_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [INST_WIDTH-1:0] i_rdata,
  output logic [INST_WIDTH-1:0] i_wdata,
  output logic [3:0]            i_wstrb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CW-1:0]         count,
  output fetch_state_e          fsm_state
);

  // Bus handshake: a request is i_valid=1 with i_addr; it completes in the cycle
  // i_ready=1, when i_rdata is also valid. Until then i_valid/i_addr are held.

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(PC_LOW_MASK);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);

  fetch_state_e            state, state_n;
  logic                    i_valid_n;
  logic [ADDR_WIDTH-1:0]   i_addr_n;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_n;
  logic [ADDR_WIDTH-1:0]   target_pc;
  logic                    push, pop;
  logic [CW-1:0]           count_after;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] head;

  assign i_wdata   = '0;
  assign i_wstrb   = '0;
  assign fsm_state = state;
  assign target_pc = redirect_pc & ALIGN_MASK;

  assign push = (state == ST_REQ) && i_ready && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;
  // Occupancy once this cycle's push/pop has landed; decides whether to keep fetching.
  assign count_after = count + CW'(push) - CW'(pop);

  fetch_fifo #(
    .WIDTH(ADDR_WIDTH + INST_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({i_addr, i_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .head_valid(out_valid),
    .count     (count)
  );

  assign out_pc   = head[INST_WIDTH +: ADDR_WIDTH];
  assign out_inst = head[INST_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      i_valid  <= 1'b0;
      i_addr   <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      i_valid  <= i_valid_n;
      i_addr   <= i_addr_n;
      fetch_pc <= fetch_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    i_valid_n  = i_valid;
    i_addr_n   = i_addr;
    fetch_pc_n = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_n = target_pc;
      // An un-acked request cannot be withdrawn, so its response is discarded later.
      if (state == ST_IDLE || i_ready) begin
        i_valid_n = 1'b1;
        i_addr_n  = target_pc;
        state_n   = ST_REQ;
      end else begin
        state_n = ST_DISCARD;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (count_after < CW'(DEPTH)) begin
            i_valid_n = 1'b1;
            i_addr_n  = fetch_pc;
            state_n   = ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ready) begin
            fetch_pc_n = i_addr + PC_STEP;
            if (count_after < CW'(DEPTH)) begin
              i_addr_n = i_addr + PC_STEP;
            end else begin
              i_valid_n = 1'b0;
              state_n   = ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (i_ready) begin
            i_addr_n = fetch_pc;
            state_n  = ST_REQ;
          end
        end
        default: begin
          i_valid_n = 1'b0;
          state_n   = ST_IDLE;
        end
      endcase
    end
  end

endmodule
